// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared TCDM constants, response record and LFSR step function
package hwpe_stream_package;

    localparam int unsigned TCDM_DATA_W = 32;
    localparam int unsigned TCDM_BE_W   = 4;
    localparam logic [TCDM_DATA_W-1:0] TCDM_ERR_PATTERN = 32'hDEADBEEF;

    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [TCDM_DATA_W-1:0] data;
    } tcdm_resp_t;

    // Fibonacci step, taps 16,14,13,11 (bit 15 is tap 16)
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_stall_lfsr.sv
// rtl/hwpe_stream_tcdm_stall_lfsr.sv - free-running LFSR producing a ~25% grant stall
module hwpe_stream_tcdm_stall_lfsr
    import hwpe_stream_package::*;
#(
    parameter bit          STALL_EN   = 1'b0,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic stall_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr16_next(lfsr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_o = STALL_EN && (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// rtl/hwpe_stream_tcdm_responder.sv - TCDM slave endpoint backed by a byte-enabled scratchpad bank
module hwpe_stream_tcdm_responder
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_WORDS   = 1024,
    parameter bit          STALL_EN   = 1'b0,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [31:0]            add_i,
    input  logic                   wen_i,
    input  logic [TCDM_BE_W-1:0]   be_i,
    input  logic [TCDM_DATA_W-1:0] data_i,
    output logic [TCDM_DATA_W-1:0] r_data_o,
    output logic                   r_valid_o,
    output logic                   err_o,
    output logic [31:0]            nb_reads_o,
    output logic [31:0]            nb_writes_o
);

    localparam int unsigned AW = $clog2(NB_WORDS);

    logic                   stall;
    logic                   gnt;
    logic                   in_range;
    logic [AW-1:0]          word_idx;
    logic                   unused_addr_lsb;
    logic [TCDM_DATA_W-1:0] mem_q [NB_WORDS];
    tcdm_resp_t             resp_q;
    tcdm_resp_t             resp_d;
    logic [31:0]            rd_cnt_q;
    logic [31:0]            rd_cnt_d;
    logic [31:0]            wr_cnt_q;
    logic [31:0]            wr_cnt_d;

    hwpe_stream_tcdm_stall_lfsr #(
        .STALL_EN   (STALL_EN),
        .STALL_SEED (STALL_SEED)
    ) i_stall_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_o (stall)
    );

    assign gnt             = req_i & enable_i & ~stall & ~rst_i;
    assign word_idx        = add_i[AW+1:2];
    assign in_range        = {2'b00, add_i[31:2]} < 32'(NB_WORDS);
    assign unused_addr_lsb = ^add_i[1:0];

    always_ff @(posedge clk_i) begin
        if (gnt && !wen_i && in_range) begin
            for (int i = 0; i < int'(TCDM_BE_W); i++) begin
                if (be_i[i]) begin
                    mem_q[word_idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        resp_d       = resp_q;
        resp_d.valid = 1'b0;
        resp_d.err   = 1'b0;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        if (gnt) begin
            resp_d.err = ~in_range;
            if (wen_i) begin
                resp_d.valid = 1'b1;
                resp_d.data  = in_range ? mem_q[word_idx] : TCDM_ERR_PATTERN;
                rd_cnt_d     = rd_cnt_q + 32'd1;
            end else begin
                wr_cnt_d     = wr_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            resp_q   <= resp_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Outputs are forced to reset values while rst_i is high so a response
    // registered just before reset never escapes during the reset cycle.
    assign gnt_o       = gnt;
    assign r_valid_o   = resp_q.valid & ~rst_i;
    assign err_o       = resp_q.err & ~rst_i;
    assign r_data_o    = rst_i ? '0 : resp_q.data;
    assign nb_reads_o  = rst_i ? '0 : rd_cnt_q;
    assign nb_writes_o = rst_i ? '0 : wr_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// tb/tb_hwpe_stream_tcdm_responder.sv - self-checking bench for hwpe_stream_tcdm_responder
module tb_hwpe_stream_tcdm_responder;

    localparam int NW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en;
    logic        req   [2];
    logic [31:0] add   [2];
    logic        wen   [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic        gnt   [2];
    logic [31:0] rdata [2];
    logic        rvalid[2];
    logic        err   [2];
    logic [31:0] nrd   [2];
    logic [31:0] nwr   [2];

    hwpe_stream_tcdm_responder #(.NB_WORDS(NW), .STALL_EN(1'b0), .STALL_SEED(16'hACE1)) dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .req_i(req[0]), .gnt_o(gnt[0]),
        .add_i(add[0]), .wen_i(wen[0]), .be_i(be[0]), .data_i(wdata[0]),
        .r_data_o(rdata[0]), .r_valid_o(rvalid[0]), .err_o(err[0]),
        .nb_reads_o(nrd[0]), .nb_writes_o(nwr[0]));

    hwpe_stream_tcdm_responder #(.NB_WORDS(NW), .STALL_EN(1'b1), .STALL_SEED(16'hACE1)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .req_i(req[1]), .gnt_o(gnt[1]),
        .add_i(add[1]), .wen_i(wen[1]), .be_i(be[1]), .data_i(wdata[1]),
        .r_data_o(rdata[1]), .r_valid_o(rvalid[1]), .err_o(err[1]),
        .nb_reads_o(nrd[1]), .nb_writes_o(nwr[1]));

    typedef struct {
        int          cyc;
        logic        vld;
        logic        er;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    sb_t         sb0[$];
    sb_t         sb1[$];
    logic [31:0] model [2][NW];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en [2];
    int          exp_rd [2];
    int          exp_wr [2];
    int          act    [2];
    int          grants [2];
    logic [15:0] lm;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        lm <= rst ? 16'hACE1 : {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
    end

    task automatic mon(input int d);
        sb_t  e;
        bit   have;
        logic ev, ee;
        have = 0;
        if (!mon_en[d]) return;
        if (d == 0) begin
            while (sb0.size() > 0 && sb0[0].cyc < cyc) begin
                e = sb0.pop_front();
                chk("sb0_stale", e.cyc, cyc);
            end
            if (sb0.size() > 0 && sb0[0].cyc == cyc) begin e = sb0.pop_front(); have = 1; end
        end else begin
            while (sb1.size() > 0 && sb1[0].cyc < cyc) begin
                e = sb1.pop_front();
                chk("sb1_stale", e.cyc, cyc);
            end
            if (sb1.size() > 0 && sb1[0].cyc == cyc) begin e = sb1.pop_front(); have = 1; end
        end
        ev = have ? e.vld : 1'b0;
        ee = have ? e.er  : 1'b0;
        chk($sformatf("r_valid%0d", d), rvalid[d], ev);
        chk($sformatf("err%0d", d), err[d], ee);
        if (ev) chk($sformatf("r_data%0d", d), rdata[d], e.data);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        if (mon_en[1])
            chk("gnt1_lfsr", gnt[1], req[1] & en & ~rst & (lm[1:0] != 2'b00));
    end

    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] dt, input bit use_tbl, input logic [31:0] texp);
        int          n;
        sb_t         e;
        bit          inr;
        logic [5:0]  idx;
        logic [31:0] rexp;
        @(posedge clk); #1;
        req[d] = 1'b1; add[d] = a; wen[d] = w; be[d] = b; wdata[d] = dt;
        n = 0;
        forever begin
            @(negedge clk);
            act[d]++;
            if (gnt[d] === 1'b1) break;
            n++;
            if (n >= 64) begin
                chk("gnt_timeout", 32'd0, 32'd1);
                req[d] = 1'b0;
                return;
            end
        end
        grants[d]++;
        inr    = (a[31:2] < NW);
        idx    = a[7:2];
        e.cyc  = cyc + 1;
        e.vld  = w;
        e.er   = !inr;
        e.data = '0;
        if (w) begin
            rexp = inr ? model[d][idx] : 32'hDEADBEEF;
            if (use_tbl) rexp = texp;
            e.data = rexp;
            exp_rd[d]++;
        end else begin
            exp_wr[d]++;
            if (inr)
                for (int i = 0; i < 4; i++)
                    if (b[i]) model[d][idx][8*i +: 8] = dt[8*i +: 8];
        end
        if (w || !inr) begin
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_counts(input int d);
        chk($sformatf("nb_reads%0d", d), nrd[d], exp_rd[d]);
        chk($sformatf("nb_writes%0d", d), nwr[d], exp_wr[d]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [11];
        int   ratio;
        tv[0]  = '{1'b0, 32'h10,       4'hF,    32'h1234_5678, 32'h0};
        tv[1]  = '{1'b1, 32'h10,       4'h0,    32'h0,         32'h1234_5678};
        tv[2]  = '{1'b0, 32'h20,       4'hF,    32'hAABB_CCDD, 32'h0};
        tv[3]  = '{1'b0, 32'h20,       4'b0010, 32'h0000_EE00, 32'h0};
        tv[4]  = '{1'b1, 32'h20,       4'h0,    32'h0,         32'hAABB_EEDD};
        tv[5]  = '{1'b0, 32'h24,       4'hF,    32'hFFFF_FFFF, 32'h0};
        tv[6]  = '{1'b0, 32'h24,       4'b1001, 32'h1122_3344, 32'h0};
        tv[7]  = '{1'b1, 32'h24,       4'h0,    32'h0,         32'h11FF_FF44};
        tv[8]  = '{1'b1, 32'h100,      4'h0,    32'h0,         32'hDEAD_BEEF};
        tv[9]  = '{1'b1, 32'h13,       4'h0,    32'h0,         32'h1234_5678};
        tv[10] = '{1'b1, 32'hFFFF_FFFC, 4'h0,   32'h0,         32'hDEAD_BEEF};

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b1; add[d] = '0; wen[d] = 1'b1; be[d] = '0; wdata[d] = '0;
            mon_en[d] = 0; exp_rd[d] = 0; exp_wr[d] = 0; act[d] = 0; grants[d] = 0;
        end
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_gnt%0d", d), gnt[d], 1'b0);
            chk($sformatf("rst_rvalid%0d", d), rvalid[d], 1'b0);
            chk($sformatf("rst_rdata%0d", d), rdata[d], 32'h0);
            chk($sformatf("rst_err%0d", d), err[d], 1'b0);
            chk_counts(d);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        mon_en[0] = 1;
        mon_en[1] = 1;

        for (int i = 0; i < NW; i++) xact(0, 1'b0, 32'(i * 4), 4'hF, $urandom, 0, '0);
        for (int i = 0; i < 11; i++) xact(0, tv[i].w, tv[i].a, tv[i].b, tv[i].d, 1, tv[i].e);
        idle(2);
        chk_counts(0);

        xact(0, 1'b0, 32'h30, 4'hF, 32'hCAFE_F00D, 0, '0);
        xact(0, 1'b1, 32'h30, 4'h0, 32'h0, 1, 32'hCAFE_F00D);
        for (int i = 0; i < 8; i++) xact(0, 1'b1, 32'(i * 4), 4'h0, 32'h0, 0, '0);
        idle(2);

        xact(0, 1'b0, 32'(NW * 4), 4'hF, 32'h0BAD_0BAD, 0, '0);
        xact(0, 1'b0, 32'(NW * 4 + 8), 4'hF, 32'h0BAD_0BAD, 0, '0);
        for (int i = 0; i < NW; i++) xact(0, 1'b1, 32'(i * 4), 4'h0, 32'h0, 0, '0);
        idle(2);
        chk_counts(0);

        xact(0, 1'b1, 32'h20, 4'h0, 32'h0, 0, '0);
        fork
            xact(0, 1'b1, 32'h24, 4'h0, 32'h0, 0, '0);
            begin
                @(posedge clk); #1;
                en = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("gnt_disabled", gnt[0], 1'b0);
                end
                @(posedge clk); #1;
                en = 1'b1;
            end
        join
        idle(2);
        chk_counts(0);

        xact(0, 1'b1, 32'h10, 4'h0, 32'h0, 0, '0);
        mon_en[0] = 0;
        sb0.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", rvalid[0], 1'b0);
        chk("mid_rst_rdata", rdata[0], 32'h0);
        chk("mid_rst_err", err[0], 1'b0);
        chk("mid_rst_gnt", gnt[0], 1'b0);
        chk("mid_rst_nb_reads", nrd[0], 32'h0);
        chk("mid_rst_nb_writes", nwr[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin exp_rd[d] = 0; exp_wr[d] = 0; end
        @(negedge clk);
        chk("post_rst_gnt", gnt[0], 1'b1);
        chk("post_rst_nb_reads", nrd[0], 32'h0);
        begin
            sb_t e;
            e.cyc = cyc + 1; e.vld = 1'b1; e.er = 1'b0; e.data = model[0][4];
            sb0.push_back(e);
        end
        exp_rd[0] = 1;
        mon_en[0] = 1;
        idle(2);
        chk_counts(0);

        for (int i = 0; i < NW; i++) xact(1, 1'b0, 32'(i * 4), 4'hF, $urandom, 0, '0);
        act[1] = 0;
        grants[1] = 0;
        for (int i = 0; i < 1000; i++)
            xact(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, NW + 6) * 4),
                 4'($urandom_range(0, 15)), $urandom, 0, '0);
        idle(3);
        chk_counts(1);
        ratio = (act[1] > 0) ? (grants[1] * 100) / act[1] : 0;
        chk("grant_ratio_in_60_90", 32'(ratio >= 60 && ratio <= 90), 32'd1);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
